// File: rtl/obc_shift_accumulator_if.sv
// Handshake and ROM-slice bundle for the OBC shift-accumulator.
// The master drives requests and ROM words; the slave returns slice index and result.
interface obc_shift_accumulator_if #(
   parameter int DATA_W = 16,
   parameter int ROM_W  = 32
);
   localparam int BW = $clog2(DATA_W);

   logic             start;
   logic [ROM_W-1:0] offset;
   logic [ROM_W-1:0] rom0;
   logic [ROM_W-1:0] rom1;
   logic [ROM_W-1:0] rom2;
   logic [ROM_W-1:0] rom3;
   logic [BW-1:0]    bit_idx;
   logic             ready_in;
   logic             busy;
   logic [ROM_W-1:0] result;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output start, offset, rom0, rom1, rom2, rom3, out_ready,
      input  bit_idx, ready_in, busy, result, out_valid
   );

   modport slave (
      input  start, offset, rom0, rom1, rom2, rom3, out_ready,
      output bit_idx, ready_in, busy, result, out_valid
   );
endinterface

// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC accumulator: sums four ROM words per slice, shift-accumulates
// LSB-first, subtracts the sign slice, adds the offset and saturates.
module obc_shift_accumulator #(
   parameter int DATA_W = 16,
   parameter int ROM_W  = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   obc_shift_accumulator_if.slave bus
);
   localparam int BW = $clog2(DATA_W);
   localparam int SW = ROM_W + 2;
   localparam int G  = DATA_W - 1;
   localparam int AW = SW + G;
   localparam int FW = AW + 2;
   localparam int RW = FW - G;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [ROM_W-1:0] off_q, off_d;
   logic [ROM_W-1:0] res_q, res_d;

   logic [SW-1:0]    s;
   logic [AW-1:0]    s_sh;
   logic [AW:0]      step;
   logic [FW-1:0]    fin;
   logic [RW-1:0]    fin_sh;
   logic             ovf;
   logic [ROM_W-1:0] res_sat;
   logic             last;

   assign s = {{2{bus.rom0[ROM_W-1]}}, bus.rom0}
            + {{2{bus.rom1[ROM_W-1]}}, bus.rom1}
            + {{2{bus.rom2[ROM_W-1]}}, bus.rom2}
            + {{2{bus.rom3[ROM_W-1]}}, bus.rom3};

   assign s_sh = {s, {G{1'b0}}};

   // One extra bit so the pre-shift sum cannot wrap
   assign step = {acc_q[AW-1], acc_q} + {s_sh[AW-1], s_sh};

   assign fin = {{2{acc_q[AW-1]}}, acc_q}
              - {{2{s_sh[AW-1]}}, s_sh}
              + {{(FW-ROM_W-G){off_q[ROM_W-1]}}, off_q, {G{1'b0}}};

   assign fin_sh = fin[FW-1:G];
   assign ovf    = !((&fin_sh[RW-1:ROM_W-1]) || !(|fin_sh[RW-1:ROM_W-1]));

   assign res_sat = !ovf ? fin_sh[ROM_W-1:0] :
                    fin_sh[RW-1] ? {1'b1, {(ROM_W-1){1'b0}}} :
                                   {1'b0, {(ROM_W-1){1'b1}}};

   assign last = (idx_q == BW'(DATA_W-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         off_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         off_q   <= off_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      off_d   = off_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               off_d   = bus.offset;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (last) begin
               res_d   = res_sat;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               acc_d = step[AW:1];
               idx_d = idx_q + BW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (bus.start) begin
                  off_d   = bus.offset;
                  acc_d   = '0;
                  idx_d   = '0;
                  state_d = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.bit_idx   = idx_q;
   assign bus.busy      = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.ready_in  = (state_q == IDLE) ||
                          ((state_q == DONE) && bus.out_ready);
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Directed self-checking bench for obc_shift_accumulator.
// ROM words are driven from bit_idx with a per-test value/slice selection.
module tb_obc_shift_accumulator;
   localparam int DW = 16;
   localparam int RW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obc_shift_accumulator_if #(.DATA_W(DW), .ROM_W(RW)) bus ();

   obc_shift_accumulator #(.DATA_W(DW), .ROM_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [RW-1:0] rv [4];
   int            sl;

   always_comb begin
      bus.rom0 = '0;
      bus.rom1 = '0;
      bus.rom2 = '0;
      bus.rom3 = '0;
      if (sl < 0 || int'(bus.bit_idx) == sl) begin
         bus.rom0 = rv[0];
         bus.rom1 = rv[1];
         bus.rom2 = rv[2];
         bus.rom3 = rv[3];
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_roms(input logic [RW-1:0] a, input logic [RW-1:0] b,
                           input logic [RW-1:0] c, input logic [RW-1:0] d,
                           input int s);
      rv[0] = a;
      rv[1] = b;
      rv[2] = c;
      rv[3] = d;
      sl    = s;
   endtask

   // Start one computation and wait (bounded) for out_valid; lat=-1 on timeout
   task automatic run(input logic [RW-1:0] off, output int lat,
                      output logic [RW-1:0] res);
      bus.offset = off;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      if (bus.out_valid !== 1'b1) lat = -1;
      res = bus.result;
   endtask

   task automatic drain;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.result !== 32'h0 || bus.bit_idx !== 4'd0 ||
          bus.ready_in !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: got v=%b b=%b r=%h i=%0d rdy=%b required 0 0 0 0 1",
                  bus.out_valid, bus.busy, bus.result, bus.bit_idx, bus.ready_in);
      end
   endtask

   task automatic test_offset_only;
      int bad;
      set_roms(0, 0, 0, 0, -1);
      bus.offset = 32'h0000_1000;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      bad = 0;
      for (int c = 1; c <= 16; c++) begin
         if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
         tick();
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL offset_busy: got %0d bad cycles required 0", bad);
      end
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL offset_latency: got v=%b b=%b at cycle 17 required 1 0",
                  bus.out_valid, bus.busy);
      end
      n_chk++;
      if (bus.result !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL offset_result: got %h required 00001000", bus.result);
      end
      drain();
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL offset_drop: got v=%b required 0", bus.out_valid);
      end
   endtask

   task automatic test_slices;
      int lat;
      logic [RW-1:0] res;
      logic [RW-1:0] va [8];
      logic [RW-1:0] vb [8];
      int            si [8];
      logic [RW-1:0] of [8];
      logic [RW-1:0] ex [8];
      string         nm [8];
      va = '{32'h0001_0000, 32'h0008_0000, 32'h0020_0000, 32'h8000_0000,
             32'h0001_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
      vb = '{32'h0, 32'h0, 32'h0, 32'h8000_0000,
             32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0};
      si = '{-1, 0, 15, 15, 14, 15, 0, 0};
      of = '{32'h0, 32'h0, 32'h0, 32'h0,
             32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
      ex = '{32'hFFFF_FFFE, 32'h0000_0010, 32'hFFE0_0000, 32'h7FFF_FFFF,
             32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
      nm = '{"constant", "single_lsb", "single_msb", "sat_pos_sign",
             "sat_pos_off", "sat_neg", "floor_pos", "floor_neg"};
      for (int k = 0; k < 8; k++) begin
         set_roms(va[k], vb[k], vb[k], vb[k], si[k]);
         run(of[k], lat, res);
         n_chk++;
         if (lat != 17) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required 17", nm[k], lat);
         end
         n_chk++;
         if (res !== ex[k]) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm[k], res, ex[k]);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [RW-1:0] res;
      set_roms(0, 0, 0, 0, -1);
      run(32'h0000_1234, lat, res);
      n_chk++;
      if (res !== 32'h0000_1234 || lat != 17) begin
         n_fail++;
         $display("FAIL bp_first: got %h lat %0d required 00001234 lat 17", res, lat);
      end
      for (int c = 0; c < 5; c++) begin
         bus.out_ready = 1'b0;
         bus.start     = (c % 2 == 0);
         bus.offset    = 32'h0000_DEAD;
         #1;
         n_chk++;
         if (bus.ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_in: got %b required 0", bus.ready_in);
         end
         tick();
         n_chk++;
         if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_1234 ||
             bus.busy !== 1'b0 || bus.bit_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b r=%h b=%b i=%0d required 1 00001234 0 0",
                     bus.out_valid, bus.result, bus.busy, bus.bit_idx);
         end
      end
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      bus.offset    = 32'h0000_0055;
      #1;
      n_chk++;
      if (bus.ready_in !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready_in: got %b required 1", bus.ready_in);
      end
      tick();
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      n_chk++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_enter: got b=%b v=%b required 1 0", bus.busy, bus.out_valid);
      end
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      n_chk++;
      if (lat != 17 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_latency: got %0d required 17", lat);
      end
      n_chk++;
      if (bus.result !== 32'h0000_0055) begin
         n_fail++;
         $display("FAIL b2b_result: got %h required 00000055", bus.result);
      end
      drain();
   endtask

   task automatic test_reset_mid_op;
      int n;
      int seen;
      set_roms(32'h0100_0000, 0, 0, 0, -1);
      bus.offset = 32'h0000_0777;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.bit_idx !== 4'd7 && n < 20) begin
         tick();
         n++;
      end
      n_chk++;
      if (bus.bit_idx !== 4'd7) begin
         n_fail++;
         $display("FAIL rst_reach_idx7: got %0d required 7", bus.bit_idx);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.result !== 32'h0 || bus.bit_idx !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_mid_op: got v=%b b=%b r=%h i=%0d required 0 0 0 0",
                  bus.out_valid, bus.busy, bus.result, bus.bit_idx);
      end
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
      end
      n_chk++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL rst_quiet: got %0d active cycles required 0", seen);
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.offset    = '0;
      bus.out_ready = 1'b0;
      set_roms(0, 0, 0, 0, -1);
      #2;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_reset();
      test_offset_only();
      test_slices();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/obc_shift_accumulator.md
Name: obc_shift_accumulator

Overview:
- Bit-serial OBC accumulator that sits directly downstream of the imaginary/real partial-sum ROMs in the 16-point DFT datapath.
- Each cycle it drives a bit index to the upstream bit-slicer, sums the four 32-bit ROM words returned for that slice, and shift-accumulates them LSB-first.
- After the MSB (sign) slice it subtracts that slice, adds the OBC offset constant, and presents one 32-bit DFT output coefficient with a valid/ready handshake.

Parameters:
- DATA_W, 16, input sample width = number of bit slices per computation (>=2).
- ROM_W, 32, ROM word width; signed format 1 sign / 10 integer / 21 fraction bits.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new computation; accepted only when `ready_in`=1.
- offset, input, ROM_W, signed OBC constant term; sampled on the cycle `start` is accepted.
- rom0, input, ROM_W, signed ROM word for the current slice, input pair (x0,x1).
- rom1, input, ROM_W, signed ROM word for the current slice, input pair (x2,x3).
- rom2, input, ROM_W, signed ROM word for the current slice, input pair (x4,x5).
- rom3, input, ROM_W, signed ROM word for the current slice, input pair (x6,x7).
- bit_idx, output, clog2(DATA_W), slice index sent to the upstream slicer; rom0..3 respond combinationally in the same cycle.
- ready_in, output, 1, high in IDLE, or in DONE when `out_ready`=1.
- busy, output, 1, high in ACCUM.
- result, output, ROM_W, signed saturated coefficient.
- out_valid, output, 1, `result` is valid.
- out_ready, input, 1, downstream accepts `result`.

Behaviour:
- Reset values (async, all registers): state=IDLE, bit_idx=0, acc=0, offset register=0, result=0, out_valid=0, busy=0.
- States:
  - IDLE: on `start`, load offset register, acc=0, bit_idx=0, go to ACCUM.
  - ACCUM: one slice per cycle.
  - DONE: `out_valid`=1.
- Slice sum: s = sign-extended sum of rom0..rom3, exact at ROM_W+2 bits.
- Accumulator: acc is ROM_W+2+(DATA_W-1) bits wide. The low DATA_W-1 bits are guard fraction bits, so no precision is lost during accumulation.
- Per ACCUM cycle, with j = bit_idx:
  - If j < DATA_W-1: acc <= (acc + (s << (DATA_W-1))) >>> 1 (arithmetic shift); bit_idx <= j+1.
  - If j = DATA_W-1: final = acc - (s << (DATA_W-1)) + (offset << (DATA_W-1)). result <= saturate(final >>> (DATA_W-1)) to ROM_W bits; go to DONE; bit_idx <= 0.
- Net function: result = floor( -D(N-1) + sum over j<N-1 of D(j)*2^-(N-1-j) + offset ), where N = DATA_W and D(j) is the slice sum at index j.
- Rounding and range: floor by truncation of guard bits. Saturate to 0x7FFFFFFF / 0x80000000 on overflow.
- Latency: `start` accepted at cycle 0; DATA_W ACCUM cycles; out_valid=1 from cycle DATA_W+1.
- DONE:
  - out_valid and result hold stable until `out_ready`=1.
  - On the handshake, if `start`=1 in the same cycle, go straight to ACCUM (back-to-back, no bubble) with the new offset; otherwise go to IDLE and drop out_valid.
- `start` while busy, or in DONE without `out_ready`: ignored, no effect.
- bit_idx changes only in ACCUM. It is 0 in IDLE and DONE.
- rst_n asserted mid-ACCUM or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.

Test Plan:
- Offset only: rom0..3=0, offset=0x00001000, start -> out_valid at cycle 17 (DATA_W=16), result=0x00001000, busy high for cycles 1..16.
- Constant slices: rom0=0x00010000, others 0, all slices, offset=0 -> result = -0x00010000*2^-15 = 0xFFFFFFFE.
- Single slices (bench drives rom0 from bit_idx):
  - rom0=0x00080000 only when bit_idx=0 -> result=0x00000010.
  - rom0=0x00200000 only when bit_idx=15 -> result=0xFFE00000.
- Saturation: all four ROMs=0x80000000 only when bit_idx=15 -> result=0x7FFFFFFF; offset=0x7FFFFFFF with rom0=0x00010000 only at bit_idx=14 -> positive overflow also clamps to 0x7FFFFFFF.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> result stable, start pulses ignored.
  - Then out_ready=1 with start=1 -> next computation begins in the same cycle, next out_valid exactly 17 cycles later.
- Reset mid-op: deassert rst_n at bit_idx=7 -> all outputs zero immediately; after release with no start, out_valid stays 0 for 40 cycles.
